// File: rtl/instr_sequencer.sv
// instr_sequencer: program counter and issue controller that fetches
// 16-bit instructions from synchronous memory and drives cpu in/load/s/w.
module instr_sequencer #(
   parameter int          ADDR_W   = 8,
   parameter int          WAIT_MAX = 16,
   parameter logic [2:0]  HALT_OP  = 3'b111
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [15:0]       mem_rdata,
   output logic [15:0]       cpu_in,
   output logic              cpu_load,
   output logic              cpu_s,
   input  logic              cpu_w,
   output logic              busy,
   output logic              done,
   output logic              timeout_err,
   output logic [ADDR_W-1:0] pc,
   output logic [15:0]       instr_count
);

   localparam int WD_W = $clog2(WAIT_MAX + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(WAIT_MAX - 1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      MEMWAIT,
      LOAD,
      ISSUE,
      GAP,
      WAIT_W,
      FINISH
   } state_t;

   state_t            state;
   logic [WD_W-1:0]   wd;
   logic [ADDR_W-1:0] pc_inc;

   // next sequential address, wrapping silently at the top of memory
   assign pc_inc = pc + ADDR_W'(1);

   // sequencer FSM; every output is set on entry to the state that owns it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         wd          <= '0;
         pc          <= '0;
         mem_addr    <= '0;
         mem_rd      <= 1'b0;
         cpu_in      <= '0;
         cpu_load    <= 1'b0;
         cpu_s       <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         timeout_err <= 1'b0;
         instr_count <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start && cpu_w) begin
                  pc          <= base_addr;
                  mem_addr    <= base_addr;
                  mem_rd      <= 1'b1;
                  instr_count <= '0;
                  timeout_err <= 1'b0;
                  busy        <= 1'b1;
                  state       <= FETCH;
               end
            end
            FETCH: begin
               mem_rd <= 1'b0;
               state  <= MEMWAIT;
            end
            MEMWAIT: begin
               // cpu_in doubles as the instruction register; a HALT
               // word never reaches it so the last issued one is kept
               if (mem_rdata[15:13] == HALT_OP) begin
                  done  <= 1'b1;
                  state <= FINISH;
               end else begin
                  cpu_in   <= mem_rdata;
                  cpu_load <= 1'b1;
                  state    <= LOAD;
               end
            end
            LOAD: begin
               cpu_load <= 1'b0;
               cpu_s    <= 1'b1;
               state    <= ISSUE;
            end
            ISSUE: begin
               cpu_s <= 1'b0;
               if (instr_count != 16'hFFFF)
                  instr_count <= instr_count + 16'd1;
               wd    <= '0;
               state <= GAP;
            end
            GAP: begin
               // cpu.w is still high while the cpu samples s
               state <= WAIT_W;
            end
            WAIT_W: begin
               wd <= wd + WD_W'(1);
               if (cpu_w) begin
                  pc       <= pc_inc;
                  mem_addr <= pc_inc;
                  mem_rd   <= 1'b1;
                  state    <= FETCH;
               end else if (wd == WD_LAST) begin
                  timeout_err <= 1'b1;
                  done        <= 1'b1;
                  state       <= FINISH;
               end
            end
            FINISH: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: random programs run against a queue-based model,
// with a behavioural memory and a small cpu stub around the sequencer.
module tb_instr_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        start;
   logic [7:0]  base_addr;
   logic [7:0]  mem_addr;
   logic        mem_rd;
   logic [15:0] mem_rdata;
   logic [15:0] cpu_in;
   logic        cpu_load;
   logic        cpu_s;
   logic        cpu_w;
   logic        busy;
   logic        done;
   logic        timeout_err;
   logic [7:0]  pc;
   logic [15:0] instr_count;

   int n_tests = 0;
   int n_fail  = 0;

   instr_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .base_addr   (base_addr),
      .mem_addr    (mem_addr),
      .mem_rd      (mem_rd),
      .mem_rdata   (mem_rdata),
      .cpu_in      (cpu_in),
      .cpu_load    (cpu_load),
      .cpu_s       (cpu_s),
      .cpu_w       (cpu_w),
      .busy        (busy),
      .done        (done),
      .timeout_err (timeout_err),
      .pc          (pc),
      .instr_count (instr_count)
   );

   // synchronous program memory, one cycle read latency
   logic [15:0] mem [256];
   always @(posedge clk)
      if (mem_rd) mem_rdata <= mem[mem_addr];

   // cpu stub: w drops after s, returns after a random latency
   logic        stub_w = 1'b1;
   logic        hang   = 1'b0;
   logic        w_low  = 1'b0;
   int          lat    = 0;
   logic [15:0] ir     = '0;
   logic [15:0] regs [8];
   assign cpu_w = stub_w & ~w_low;

   function automatic logic [15:0] shf(input logic [15:0] v,
                                       input logic [1:0] sh);
      case (sh)
         2'd1:    return {v[14:0], 1'b0};
         2'd2:    return {1'b0, v[15:1]};
         2'd3:    return {v[15], v[15:1]};
         default: return v;
      endcase
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         stub_w <= 1'b1;
         lat    <= 0;
      end else begin
         if (cpu_load) ir <= cpu_in;
         if (stub_w && cpu_s) begin
            stub_w <= 1'b0;
            lat    <= int'($urandom_range(0, 3));
         end else if (!stub_w && !hang) begin
            if (lat == 0) begin
               stub_w <= 1'b1;
               if (ir[15:11] == 5'b11010)
                  regs[ir[10:8]] <= {{8{ir[7]}}, ir[7:0]};
               else if (ir[15:11] == 5'b10100)
                  regs[ir[7:5]] <= regs[ir[10:8]]
                                 + shf(regs[ir[2:0]], ir[4:3]);
            end else begin
               lat <= lat - 1;
            end
         end
      end
   end

   // passive monitor: issued words and strobe counts
   int          n_load = 0;
   int          n_s    = 0;
   int          n_rd   = 0;
   int          n_done = 0;
   int          n_bad  = 0;
   logic        prev_load = 1'b0;
   logic [15:0] prev_in   = '0;
   logic [15:0] obs_q [$];

   always @(negedge clk) begin
      if (cpu_load) begin
         obs_q.push_back(cpu_in);
         n_load <= n_load + 1;
      end
      if (cpu_s)  n_s    <= n_s + 1;
      if (mem_rd) n_rd   <= n_rd + 1;
      if (done)   n_done <= n_done + 1;
      if (cpu_s && (!prev_load || cpu_in !== prev_in))
         n_bad <= n_bad + 1;
      if (cpu_s && cpu_load)
         n_bad <= n_bad + 1;
      prev_load <= cpu_load;
      prev_in   <= cpu_in;
   end

   task automatic wait_done(output bit ok, output int cyc,
                            output int ts);
      ok  = 1'b0;
      cyc = 0;
      ts  = -1;
      while (!ok && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (cpu_s && ts < 0) ts = cyc;
         if (done) ok = 1'b1;
      end
   endtask

   task automatic go(input logic [7:0] base, output bit ok);
      int cyc;
      int ts;
      @(negedge clk);
      start     = 1'b1;
      base_addr = base;
      @(negedge clk);
      start = 1'b0;
      wait_done(ok, cyc, ts);
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      start     = 1'b0;
      base_addr = '0;
      reset     = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({pc, mem_addr, cpu_in, instr_count, mem_rd, cpu_load,
           cpu_s, busy, done, timeout_err} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs pc=%h addr=%h in=%h cnt=%h busy=%b",
                  pc, mem_addr, cpu_in, instr_count, busy);
      end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_tests++;
      if ({busy, mem_rd} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_idle busy=%b rd=%b exp 0 0", busy, mem_rd);
      end
   endtask

   task automatic test_basic();
      bit          ok;
      int          i0, l0, s0, d0;
      logic [15:0] got;
      mem[0] = 16'hD105;
      mem[1] = 16'hE000;
      i0 = obs_q.size();
      l0 = n_load;
      s0 = n_s;
      d0 = n_done;
      go(8'h00, ok);
      got = (obs_q.size() > i0) ? obs_q[i0] : 16'hxxxx;
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL basic_done no done pulse, exp one");
      end
      n_tests++;
      if (n_load - l0 !== 1 || n_s - s0 !== 1) begin
         n_fail++;
         $display("FAIL basic_pulses load=%0d s=%0d exp 1 1",
                  n_load - l0, n_s - s0);
      end
      n_tests++;
      if (got !== 16'hD105 || cpu_in !== 16'hD105) begin
         n_fail++;
         $display("FAIL basic_in got %h hold %h exp d105", got, cpu_in);
      end
      n_tests++;
      if (instr_count !== 16'd1 || pc !== 8'd1) begin
         n_fail++;
         $display("FAIL basic_cnt_pc cnt=%0d pc=%h exp 1 01",
                  instr_count, pc);
      end
      n_tests++;
      if (timeout_err !== 1'b0 || busy !== 1'b0 || n_done - d0 !== 1) begin
         n_fail++;
         $display("FAIL basic_status terr=%b busy=%b dones=%0d exp 0 0 1",
                  timeout_err, busy, n_done - d0);
      end
      n_tests++;
      if (regs[1] !== 16'd5) begin
         n_fail++;
         $display("FAIL basic_r1 got %0d exp 5", regs[1]);
      end
   endtask

   task automatic test_multi();
      bit          ok;
      int          i0;
      logic [15:0] prog [4];
      bit          seq_ok;
      prog[0] = 16'hD007;
      prog[1] = 16'hD102;
      prog[2] = 16'hA148;
      prog[3] = 16'hE000;
      for (int j = 0; j < 4; j++) mem[4 + j] = prog[j];
      i0 = obs_q.size();
      go(8'h04, ok);
      seq_ok = ok && (obs_q.size() == i0 + 3);
      for (int j = 0; j < 3 && seq_ok; j++)
         if (obs_q[i0 + j] !== prog[j]) seq_ok = 1'b0;
      n_tests++;
      if (!seq_ok) begin
         n_fail++;
         $display("FAIL multi_order issued=%0d done=%b exp 3 in order",
                  obs_q.size() - i0, ok);
      end
      n_tests++;
      if (regs[2] !== 16'd16) begin
         n_fail++;
         $display("FAIL multi_cpu_out got %0d exp 16", regs[2]);
      end
      n_tests++;
      if (instr_count !== 16'd3 || pc !== 8'd7) begin
         n_fail++;
         $display("FAIL multi_cnt_pc cnt=%0d pc=%h exp 3 07",
                  instr_count, pc);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 20; it++) begin
         bit          ok;
         bit          seq_ok;
         int          i0, r0, s0, len;
         logic [7:0]  base;
         logic [15:0] ins;
         logic [15:0] exp_q [$];
         base = 8'($urandom);
         len  = int'($urandom_range(1, 6));
         exp_q.delete();
         for (int j = 0; j < len; j++) begin
            ins = 16'($urandom);
            if (ins[15:13] == 3'b111) ins[15] = 1'b0;
            mem[8'(base + 8'(j))] = ins;
            exp_q.push_back(ins);
         end
         mem[8'(base + 8'(len))] = {3'b111, 13'($urandom)};
         i0 = obs_q.size();
         r0 = n_rd;
         s0 = n_s;
         go(base, ok);
         seq_ok = ok && (obs_q.size() == i0 + len);
         for (int j = 0; j < len && seq_ok; j++)
            if (obs_q[i0 + j] !== exp_q[j]) seq_ok = 1'b0;
         n_tests++;
         if (!seq_ok) begin
            n_fail++;
            $display("FAIL rand_seq it=%0d issued=%0d exp %0d", it,
                     obs_q.size() - i0, len);
         end
         n_tests++;
         if (instr_count !== 16'(len) || pc !== 8'(base + 8'(len))) begin
            n_fail++;
            $display("FAIL rand_cnt_pc it=%0d cnt=%0d pc=%h exp %0d %h",
                     it, instr_count, pc, len, 8'(base + 8'(len)));
         end
         n_tests++;
         if (n_rd - r0 !== len + 1 || n_s - s0 !== len) begin
            n_fail++;
            $display("FAIL rand_strobes it=%0d rd=%0d s=%0d exp %0d %0d",
                     it, n_rd - r0, n_s - s0, len + 1, len);
         end
      end
      n_tests++;
      if (n_bad !== 0) begin
         n_fail++;
         $display("FAIL issue_protocol bad=%0d exp 0", n_bad);
      end
   endtask

   task automatic test_wrap();
      bit ok;
      mem[8'hFF] = 16'hD32A;
      mem[8'h00] = 16'hE000;
      go(8'hFF, ok);
      n_tests++;
      if (!ok || pc !== 8'h00 || instr_count !== 16'd1) begin
         n_fail++;
         $display("FAIL wrap done=%b pc=%h cnt=%0d exp 1 00 1",
                  ok, pc, instr_count);
      end
   endtask

   task automatic test_watchdog();
      bit ok;
      int cyc, ts;
      mem[8'h40] = 16'hD105;
      mem[8'h41] = 16'hE000;
      hang = 1'b1;
      @(negedge clk);
      start     = 1'b1;
      base_addr = 8'h40;
      @(negedge clk);
      start = 1'b0;
      wait_done(ok, cyc, ts);
      n_tests++;
      if (!ok || cyc - ts !== 18) begin
         n_fail++;
         $display("FAIL wd_latency done=%b s_to_done=%0d exp 18",
                  ok, cyc - ts);
      end
      n_tests++;
      if (timeout_err !== 1'b1 || pc !== 8'h40 || instr_count !== 16'd1)
      begin
         n_fail++;
         $display("FAIL wd_state terr=%b pc=%h cnt=%0d exp 1 40 1",
                  timeout_err, pc, instr_count);
      end
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0 || timeout_err !== 1'b1) begin
         n_fail++;
         $display("FAIL wd_after busy=%b terr=%b exp 0 1",
                  busy, timeout_err);
      end
      hang = 1'b0;
      repeat (8) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_tests++;
      if (timeout_err !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL wd_clear terr=%b busy=%b exp 0 1",
                  timeout_err, busy);
      end
      wait_done(ok, cyc, ts);
      repeat (2) @(negedge clk);
      n_tests++;
      if (!ok || timeout_err !== 1'b0) begin
         n_fail++;
         $display("FAIL wd_rerun done=%b terr=%b exp 1 0", ok, timeout_err);
      end
   endtask

   task automatic test_ignored();
      bit ok;
      int cyc, ts, r0;
      mem[8'h80] = 16'hD101;
      mem[8'h81] = 16'hD202;
      mem[8'h82] = 16'hD303;
      mem[8'h83] = 16'hE000;
      mem[8'h10] = 16'hE000;
      r0 = n_rd;
      @(negedge clk);
      start     = 1'b1;
      base_addr = 8'h80;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      start     = 1'b1;
      base_addr = 8'h10;
      @(negedge clk);
      start = 1'b0;
      wait_done(ok, cyc, ts);
      repeat (2) @(negedge clk);
      n_tests++;
      if (!ok || pc !== 8'h83 || instr_count !== 16'd3 || n_rd - r0 !== 4)
      begin
         n_fail++;
         $display("FAIL busy_start pc=%h cnt=%0d rd=%0d exp 83 3 4",
                  pc, instr_count, n_rd - r0);
      end
      w_low = 1'b1;
      r0    = n_rd;
      @(negedge clk);
      start     = 1'b1;
      base_addr = 8'h20;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      n_tests++;
      if (busy !== 1'b0 || n_rd - r0 !== 0 || pc !== 8'h83
          || instr_count !== 16'd3) begin
         n_fail++;
         $display("FAIL w_low_start busy=%b rd=%0d pc=%h exp 0 0 83",
                  busy, n_rd - r0, pc);
      end
      w_low = 1'b0;
   endtask

   task automatic test_async_reset();
      bit ok;
      int cyc;
      mem[8'h20] = 16'hD105;
      mem[8'h21] = 16'hD102;
      mem[8'h22] = 16'hE000;
      @(negedge clk);
      start     = 1'b1;
      base_addr = 8'h20;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (!cpu_s && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      n_tests++;
      if (cpu_s !== 1'b1) begin
         n_fail++;
         $display("FAIL arst_find_s cpu_s=%b exp 1", cpu_s);
      end
      reset = 1'b0;
      #1;
      n_tests++;
      if ({cpu_s, busy, mem_rd, cpu_load} !== 4'b0000) begin
         n_fail++;
         $display("FAIL arst_drop s=%b busy=%b rd=%b exp 0 0 0",
                  cpu_s, busy, mem_rd);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({pc, mem_addr, cpu_in, instr_count, mem_rd, cpu_load,
           cpu_s, busy, done, timeout_err} !== '0) begin
         n_fail++;
         $display("FAIL arst_idle pc=%h in=%h cnt=%0d busy=%b exp zeros",
                  pc, cpu_in, instr_count, busy);
      end
      go(8'h20, ok);
      n_tests++;
      if (!ok || instr_count !== 16'd2 || pc !== 8'h22) begin
         n_fail++;
         $display("FAIL arst_rerun cnt=%0d pc=%h exp 2 22",
                  instr_count, pc);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout run did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_multi();
      test_random();
      test_wrap();
      test_watchdog();
      test_ignored();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Fetches 16-bit instructions from a synchronous program memory and feeds them one at a time to the cpu block via its in/load/s/w interface.
- Acts as the program counter and issue controller between program memory and the cpu.
- Handles start/stop, HALT detection, instruction counting and a watchdog on cpu completion.
- Sits above cpu at the top level, replacing manual switch-driven load/s stimulus.

Parameters:
ADDR_W, 8, program memory address width; PC wraps modulo 2^ADDR_W
WAIT_MAX, 16, maximum cycles allowed in WAIT_W before timeout error
HALT_OP, 3'b111, opcode value in instr[15:13] that ends the program

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  begin execution at base_addr; sampled only in IDLE
base_addr  input  ADDR_W  first instruction address
mem_addr  output  ADDR_W  program memory read address
mem_rd  output  1  memory read strobe; data is valid on mem_rdata exactly 1 cycle later
mem_rdata  input  16  memory read data
cpu_in  output  16  instruction to cpu.in
cpu_load  output  1  one-cycle pulse to cpu.load
cpu_s  output  1  one-cycle pulse to cpu.s
cpu_w  input  1  cpu.w, high when cpu is waiting in its reset state
busy  output  1  high from start acceptance until done
done  output  1  one-cycle pulse on normal HALT or timeout
timeout_err  output  1  sticky; set on watchdog expiry, cleared by next accepted start or reset
pc  output  ADDR_W  address of current instruction
instr_count  output  16  instructions issued since last start, saturates at 16'hFFFF

Behaviour:
- All outputs are registered.
- Reset (reset==0, asynchronous):
  - state=IDLE.
  - pc, mem_addr, cpu_in, instr_count = 0.
  - mem_rd, cpu_load, cpu_s, busy, done, timeout_err = 0.
  - Reset asserted mid-operation aborts immediately. No pulse completes; memory and cpu strobes drop at once.
- States: IDLE, FETCH, MEMWAIT, LOAD, ISSUE, GAP, WAIT_W, FINISH.
- IDLE:
  - If start==1 and cpu_w==1: pc<=base_addr, instr_count<=0, timeout_err<=0, busy<=1, go FETCH.
  - If start==1 with cpu_w==0: start is ignored and the block stays in IDLE.
- FETCH: mem_rd=1, mem_addr=pc for this one cycle; go MEMWAIT.
- MEMWAIT: capture mem_rdata into the instruction register, then branch:
  - instr[15:13]==HALT_OP: go FINISH. The HALT instruction is not issued and not counted.
  - Otherwise: go LOAD.
- LOAD: cpu_in=instr held stable, cpu_load=1 for one cycle; go ISSUE.
- ISSUE:
  - cpu_s=1 for one cycle; cpu_in is still held.
  - instr_count increments, saturating.
  - Clear watchdog counter; go GAP.
- GAP: one cycle in which cpu_w is ignored, because cpu.w is still high on the cycle it samples s. Go WAIT_W.
- WAIT_W:
  - Watchdog counter increments each cycle.
  - If cpu_w==1: pc<=pc+1 (wraps 2^ADDR_W-1 -> 0), go FETCH.
  - Else if counter==WAIT_MAX-1: timeout_err<=1, go FINISH.
- FINISH: done=1 for one cycle, busy<=0, go IDLE. pc and instr_count hold their final values.
- cpu_in holds the last issued instruction until the next LOAD.
- start asserted while busy is ignored; there is no restart.
- Minimum per-instruction cost is 6 cycles: FETCH, MEMWAIT, LOAD, ISSUE, GAP, plus one WAIT_W cycle.
- The pc wrap is silent; no error is raised.

Test Plan:
- Reset/start basic:
  - Stimulus: reset low then high; memory[0]=16'hD105 (MOV R1,#5), memory[1]=16'hE000; start=1 with base_addr=0, cpu idle (w=1).
  - Required: exactly one cpu_load then one cpu_s, cpu_in=16'hD105; then done pulse; instr_count=1, pc=1, timeout_err=0.
- Multi-instruction program:
  - Stimulus: MOV R0,#7; MOV R1,#2; ADD R2,R1,R0,LSL#1; HALT at addresses 4..7, base_addr=4.
  - Required: three issues in order; cpu out=16 (2+7*2); instr_count=3, pc=7.
- Watchdog:
  - Stimulus: with WAIT_MAX=16, a stub cpu holds w=0 after s.
  - Required: timeout_err=1 and done pulse 16 cycles after GAP; busy=0; the next start clears timeout_err.
- PC wrap:
  - Stimulus: ADDR_W=8, base_addr=8'hFF holding MOV, memory[0]=HALT.
  - Required: pc wraps to 8'h00, done asserts, instr_count=1.
- Ignored starts:
  - Stimulus: start pulsed while busy, and start pulsed while cpu_w=0 in IDLE.
  - Required: no state change, no extra mem_rd.
- Async reset mid-op:
  - Stimulus: assert reset during the cycle cpu_s is high.
  - Required: cpu_s, busy, mem_rd drop before the next clock edge; after release the block is in IDLE with all outputs 0.
